aes_encrypt_core: RTL and testbench

Iterative AES encryption core: the forward-direction counterpart of the team's inverse (decryption) core. It captures a key and a 128-bit plaintext on a start pulse and computes one round per clock, expanding the key schedule on the fly. It then presents the 128-bit cyphertext with a sticky done flag. It sits between the SPI front end, which supplies key, plaintext and start, and the SPI readback path, which consumes the cyphertext.

---
 rtl/aes_encrypt_core.sv | 185 ++++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/256 encryptor: one round per clock with on-the-fly key expansion.
// Build option: define AES_ENC_ZEROIZE_EN to clear internal state, key schedule and rcon on the final round.
module aes_encrypt_core #(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [K-1:0]   key,
    input  logic [127:0]   plaintext,
    output logic           busy,
    output logic           done,
    output logic [127:0]   cyphertext
);
    localparam int         NR     = (K == 256) ? 14 : 10;
    localparam logic [3:0] NR_L   = 4'(NR);
    localparam bit         IS_256 = (K == 256);

    generate
        if (K != 128 && K != 256) begin : g_bad_k
            $error("aes_encrypt_core: K must be 128 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] blk_a_q, blk_a_d;
    logic [127:0] blk_b_q, blk_b_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         rot_q, rot_d;
    logic         done_q, done_d;
    logic [127:0] cyph_q, cyph_d;

    logic [127:0] sub_bytes, shifted, mixed, rk_cur, new_blk, round_out, base_blk;
    logic [31:0]  key_sub, key_temp;
    logic         use_rot, last_round;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
            assign sub_bytes[127-8*gi -: 8] = sbox(state_q[127-8*gi -: 8]);
            assign shifted[127-8*gi -: 8]   = sub_bytes[127-8*SRC -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shifted[127-32*gi -: 8];
            assign a1 = shifted[119-32*gi -: 8];
            assign a2 = shifted[111-32*gi -: 8];
            assign a3 = shifted[103-32*gi -: 8];
            assign mixed[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mixed[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mixed[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mixed[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign key_sub[31-8*gi -: 8] = sbox(blk_b_q[31-8*gi -: 8]);
        end
    endgenerate

    // AES-256 alternates RotWord+rcon blocks with SubWord-only blocks; AES-128 always rotates.
    assign use_rot  = !IS_256 || rot_q;
    assign key_temp = use_rot ? ({key_sub[23:0], key_sub[31:24]} ^ {rcon_q, 24'h0}) : key_sub;
    assign base_blk = IS_256 ? blk_a_q : blk_b_q;

    assign new_blk[127:96] = base_blk[127:96] ^ key_temp;
    assign new_blk[95:64]  = base_blk[95:64]  ^ new_blk[127:96];
    assign new_blk[63:32]  = base_blk[63:32]  ^ new_blk[95:64];
    assign new_blk[31:0]   = base_blk[31:0]   ^ new_blk[63:32];

    // AES-128 derives rk_r in the round that uses it; AES-256 already holds rk_r in blk_b.
    assign rk_cur     = IS_256 ? blk_b_q : new_blk;
    assign last_round = (round_q == NR_L);
    assign round_out  = (last_round ? shifted : mixed) ^ rk_cur;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        blk_a_d = blk_a_q;
        blk_b_d = blk_b_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        rot_d   = rot_q;
        done_d  = done_q;
        cyph_d  = cyph_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = plaintext ^ key[K-1:K-128];
                    blk_a_d = key[K-1:K-128];
                    blk_b_d = key[127:0];
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    rot_d   = 1'b1;
                    done_d  = 1'b0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                blk_a_d = blk_b_q;
                blk_b_d = new_blk;
                rot_d   = ~rot_q;
                if (use_rot) rcon_d = xtime(rcon_q);
                if (last_round) begin
                    cyph_d = round_out;
                    done_d = 1'b1;
                    fsm_d  = DONE;
`ifdef AES_ENC_ZEROIZE_EN
                    state_d = '0;
                    blk_a_d = '0;
                    blk_b_d = '0;
                    rcon_d  = 8'h00;
`endif
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            blk_a_q <= '0;
            blk_b_q <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
            cyph_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            blk_a_q <= blk_a_d;
            blk_b_q <= blk_b_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
            cyph_q  <= cyph_d;
        end
    end

    assign busy       = (fsm_q == RUN);
    assign done       = done_q;
    assign cyphertext = cyph_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: AES-128 and AES-256 instances checked against FIPS-197 vectors.
module tb_aes_encrypt_core;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start128, start256;
    logic [127:0] key128, pt128, pt256;
    logic [255:0] key256;
    logic         busy128, done128, busy256, done256;
    logic [127:0] ct128, ct256;

    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt128 = 0;
    int   done_cnt256 = 0;
    exp_t q128[$];
    exp_t q256[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    aes_encrypt_core #(.K(128)) u128 (
        .clk(clk), .reset(rst), .start(start128), .key(key128), .plaintext(pt128),
        .busy(busy128), .done(done128), .cyphertext(ct128)
    );

    aes_encrypt_core #(.K(256)) u256 (
        .clk(clk), .reset(rst), .start(start256), .key(key256), .plaintext(pt256),
        .busy(busy256), .done(done256), .cyphertext(ct256)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_128(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
        exp_t x;
        @(posedge clk); #1;
        key128 = k; pt128 = p; start128 = 1'b1;
        @(posedge clk); #1;
        start128 = 1'b0;
        key128 = rand128(); pt128 = rand128();
        x.ct = e; x.due = cycle + 10;
        q128.push_back(x);
    endtask

    task automatic start_256(input logic [255:0] k, input logic [127:0] p, input logic [127:0] e);
        exp_t x;
        @(posedge clk); #1;
        key256 = k; pt256 = p; start256 = 1'b1;
        @(posedge clk); #1;
        start256 = 1'b0;
        key256 = {rand128(), rand128()}; pt256 = rand128();
        x.ct = e; x.due = cycle + 14;
        q256.push_back(x);
    endtask

    task automatic wait_done128(input int n);
        int t = 0;
        while (done_cnt128 < n && t < 40) begin
            @(negedge clk); #1; t++;
        end
        check_val("done_count128", done_cnt128, n);
    endtask

    task automatic wait_done256(input int n);
        int t = 0;
        while (done_cnt256 < n && t < 40) begin
            @(negedge clk); #1; t++;
        end
        check_val("done_count256", done_cnt256, n);
    endtask

    initial begin : mon128
        logic prev = 1'b0;
        int   bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) bcnt = 0;
            else if (busy128) bcnt++;
            if (done128 && !prev) begin
                done_cnt128++;
                if (q128.size() == 0) begin
                    check_val("spurious_done128", done128, 1'b0);
                end else begin
                    e = q128.pop_front();
                    check_val("ct128", ct128, e.ct);
                    check_val("latency128", cycle, e.due);
                    check_val("busy_cycles128", bcnt, 10);
                    $display("txn128 cycle=%0d ct=%h exp=%h busy=%0d", cycle, ct128, e.ct, bcnt);
                end
                bcnt = 0;
            end
            prev = done128;
        end
    end

    initial begin : mon256
        logic prev = 1'b0;
        int   bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) bcnt = 0;
            else if (busy256) bcnt++;
            if (done256 && !prev) begin
                done_cnt256++;
                if (q256.size() == 0) begin
                    check_val("spurious_done256", done256, 1'b0);
                end else begin
                    e = q256.pop_front();
                    check_val("ct256", ct256, e.ct);
                    check_val("latency256", cycle, e.due);
                    check_val("busy_cycles256", bcnt, 14);
                    $display("txn256 cycle=%0d ct=%h exp=%h busy=%0d", cycle, ct256, e.ct, bcnt);
                end
                bcnt = 0;
            end
            prev = done256;
        end
    end

    initial begin : main
        int cnt_snap;
        rst = 1'b1;
        start128 = 1'b0; start256 = 1'b0;
        key128 = '0; pt128 = '0; key256 = '0; pt256 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy128", busy128, 1'b0);
        check_val("rst_done128", done128, 1'b0);
        check_val("rst_ct128", ct128, 128'h0);
        check_val("rst_busy256", busy256, 1'b0);
        check_val("rst_done256", done256, 1'b0);
        check_val("rst_ct256", ct256, 128'h0);

        // App. B vector
        start_128(KEY_B, PT_B, CT_B);
        wait_done128(1);

        // Restart from DONE: old result held until the new final round
        start_128(KEY_C1, PT_C, CT_C1);
        @(negedge clk);
        check_val("b2b_done_drop", done128, 1'b0);
        check_val("b2b_hold_early", ct128, CT_B);
        repeat (8) @(negedge clk);
        check_val("b2b_hold_late", ct128, CT_B);
        check_val("b2b_done_late", done128, 1'b0);
        wait_done128(2);

        // start pulse during RUN must be ignored
        start_128(KEY_B, PT_B, CT_B);
        repeat (4) @(posedge clk);
        #1 key128 = KEY_C1; pt128 = PT_C; start128 = 1'b1;
        @(posedge clk);
        #1 start128 = 1'b0;
        wait_done128(3);
        cnt_snap = done_cnt128;
        repeat (20) @(negedge clk);
        check_val("no_extra_done", done_cnt128, cnt_snap);
        check_val("done_sticky", done128, 1'b1);
        check_val("ct_held", ct128, CT_B);

        // Reset in the middle of a run
        start_128(KEY_B, PT_B, CT_B);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        q128.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", busy128, 1'b0);
        check_val("midrst_done", done128, 1'b0);
        check_val("midrst_ct", ct128, 128'h0);
        start_128(KEY_C1, PT_C, CT_C1);
        wait_done128(4);

`ifdef AES_ENC_ZEROIZE_EN
        check_val("zero_state128", u128.state_q, 128'h0);
        check_val("zero_blk_a128", u128.blk_a_q, 128'h0);
        check_val("zero_blk_b128", u128.blk_b_q, 128'h0);
        check_val("zero_rcon128", u128.rcon_q, 128'h0);
`endif

        // AES-256 C.3 vector, then back-to-back repeat
        start_256(KEY_C3, PT_C, CT_C3);
        wait_done256(1);
        start_256(KEY_C3, PT_C, CT_C3);
        @(negedge clk);
        check_val("b2b256_done_drop", done256, 1'b0);
        check_val("b2b256_hold", ct256, CT_C3);
        wait_done256(2);

`ifdef AES_ENC_ZEROIZE_EN
        check_val("zero_state256", u256.state_q, 128'h0);
        check_val("zero_blk_a256", u256.blk_a_q, 128'h0);
        check_val("zero_blk_b256", u256.blk_b_q, 128'h0);
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
